// File: rtl/xgmii_loopback_chan.sv
// XGMII loopback channel: TX words pass through an injection stage and a
// programmable delay line to RX, with per-frame corrupt/drop/local-fault injection.
module xgmii_loopback_chan #(
  parameter int unsigned LANES     = 8,
  parameter int unsigned MAX_DELAY = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk_xgmii,
  input  logic                         reset_xgmii,
  input  logic                         cfg_en,
  input  logic [$clog2(MAX_DELAY)-1:0] cfg_delay,
  input  logic [1:0]                   cfg_mode,
  input  logic [7:0]                   cfg_nth,
  input  logic [8*LANES-1:0]           xgmii_txd,
  input  logic [LANES-1:0]             xgmii_txc,
  output logic [8*LANES-1:0]           xgmii_rxd,
  output logic [LANES-1:0]             xgmii_rxc,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic [CNT_W-1:0]             err_cnt
);

  localparam int unsigned DW     = 8 * LANES;
  localparam int unsigned WW     = DW + LANES;
  localparam int unsigned DLY_W  = $clog2(MAX_DELAY);
  localparam int unsigned NUM_SR = MAX_DELAY - 1;

  localparam logic [DW-1:0]    IDLE_D = {LANES{8'h07}};
  localparam logic [LANES-1:0] IDLE_C = {LANES{1'b1}};
  localparam logic [WW-1:0]    IDLE_W = {IDLE_C, IDLE_D};

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_INJ} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic            first_q, first_d;
  logic [7:0]      cd_q, cd_d;
  logic            fcnt_inc, ecnt_inc;
  logic [DW-1:0]   in_d, mod_d, lf_d;
  logic [LANES-1:0] in_c, mod_c, lf_c;
  logic            start_c, term_c, tgt_c;
  logic            apply_en, apply_first;
  logic [1:0]      apply_mode;
  logic [DLY_W-1:0] dly_eff;
  logic [WW-1:0]   sr_q [NUM_SR];

  // Accepted word, start/terminate detection and local-fault pattern
  always_comb begin
    in_d    = cfg_en ? xgmii_txd : IDLE_D;
    in_c    = cfg_en ? xgmii_txc : IDLE_C;
    start_c = (in_d[7:0] == 8'hFB) && in_c[0];
    term_c  = 1'b0;
    lf_d    = '0;
    lf_c    = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (in_d[8*i +: 8] == 8'hFD && in_c[i]) term_c = 1'b1;
      case (i % 4)
        0:       begin lf_d[8*i +: 8] = 8'h9C; lf_c[i] = 1'b1; end
        3:       lf_d[8*i +: 8] = 8'h01;
        default: lf_d[8*i +: 8] = 8'h00;
      endcase
    end
    tgt_c = (cd_q == 8'd1) && (cfg_nth != 8'd0) && (cfg_mode != 2'd0);
  end

  // Frame FSM, targeting and injection
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    first_d     = 1'b0;
    cd_d        = cd_q;
    fcnt_inc    = 1'b0;
    ecnt_inc    = 1'b0;
    apply_en    = 1'b0;
    apply_first = 1'b0;
    apply_mode  = mode_q;
    mod_d       = in_d;
    mod_c       = in_c;
    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          fcnt_inc = 1'b1;
          cd_d     = (cd_q <= 8'd1) ? cfg_nth : cd_q - 8'd1;
          if (tgt_c) begin
            mode_d     = cfg_mode;
            apply_en   = 1'b1;
            apply_mode = cfg_mode;
            // a single-word frame has no second word to corrupt
            ecnt_inc   = !(term_c && cfg_mode == 2'd1);
            state_d    = term_c ? S_IDLE : S_INJ;
            first_d    = 1'b1;
          end else begin
            state_d = term_c ? S_IDLE : S_PASS;
          end
        end
      end
      S_PASS: if (term_c) state_d = S_IDLE;
      S_INJ: begin
        apply_en    = 1'b1;
        apply_first = first_q;
        if (term_c) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (apply_en) begin
      case (apply_mode)
        2'd1: if (apply_first) begin
          mod_d[7:0] = 8'hFE;
          mod_c[0]   = 1'b1;
        end
        2'd2: begin mod_d = IDLE_D; mod_c = IDLE_C; end
        2'd3: begin mod_d = lf_d;   mod_c = lf_c;   end
        default: ;
      endcase
    end
    if (!cfg_en) state_d = S_IDLE;
  end

  always_ff @(posedge clk_xgmii) begin
    if (reset_xgmii) begin
      state_q   <= S_IDLE;
      mode_q    <= 2'd0;
      first_q   <= 1'b0;
      cd_q      <= cfg_nth;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      cd_q    <= cd_d;
      if (fcnt_inc && frame_cnt != {CNT_W{1'b1}}) frame_cnt <= frame_cnt + CNT_W'(1);
      if (ecnt_inc && err_cnt != {CNT_W{1'b1}})   err_cnt   <= err_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    if (32'(cfg_delay) > 32'(MAX_DELAY - 1)) dly_eff = DLY_W'(MAX_DELAY - 1);
    else                                     dly_eff = cfg_delay;
  end

  // Delay line; the output register picks the tap so total latency is 1 + delay
  always_ff @(posedge clk_xgmii) begin
    if (reset_xgmii) begin
      for (int i = 0; i < int'(NUM_SR); i++) sr_q[i] <= IDLE_W;
      xgmii_rxd <= IDLE_D;
      xgmii_rxc <= IDLE_C;
    end else begin
      sr_q[0] <= {mod_c, mod_d};
      for (int i = 1; i < int'(NUM_SR); i++) sr_q[i] <= sr_q[i-1];
      if (dly_eff == '0) begin
        xgmii_rxd <= mod_d;
        xgmii_rxc <= mod_c;
      end else begin
        {xgmii_rxc, xgmii_rxd} <= sr_q[dly_eff - DLY_W'(1)];
      end
    end
  end

endmodule
